// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  // Operation selected by the 3-bit mode input.
  typedef enum logic [2:0] {
    SRL  = 3'd0,  // logical shift right, zero fill
    SRA  = 3'd1,  // arithmetic shift right, sign fill
    SLL  = 3'd2,  // logical shift left, zero fill
    ROR  = 3'd3,  // rotate right
    ROL  = 3'd4,  // rotate left
    SIR  = 3'd5,  // serial-in right (ser_in enters at the MSB)
    SIL  = 3'd6,  // serial-in left (ser_in enters at the LSB)
    HOLD = 3'd7   // no change
  } usr_mode_e;

  // Burst sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

endpackage : usr_pkg

// File: rtl/usr_shift_core.sv
// Combinational shift datapath shared by the single-step and burst paths.
// Produces the next register value and the bit that leaves the register.
// bit_valid is low when the operation moves nothing out (HOLD, amt = 0), so the
// caller keeps its previous ser_out in that case.
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   q,
  input  usr_mode_e          mode,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   q_next,
  output logic               bit_out,
  output logic               bit_valid
);

  logic               amt_ok;
  logic [SHAMT_W-1:0] amt_m1;
  logic [WIDTH-1:0]   pre_r;
  logic [WIDTH-1:0]   pre_l;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   sra_val;

  // A zero distance, or one outside 0..WIDTH-1, moves nothing.
  assign amt_ok  = (amt != '0) && (int'(amt) < WIDTH);
  assign amt_m1  = amt - SHAMT_W'(1);

  // Shifting by (a-1) parks the outgoing bit at an end of the word, which avoids
  // computing WIDTH-a as an index: q[a-1] lands at bit 0, q[WIDTH-a] at the MSB.
  assign pre_r   = q >> amt_m1;
  assign pre_l   = q << amt_m1;

  // Rotates come from a doubled copy of the word.
  assign dbl     = {q, q};
  assign rot_r   = dbl >> amt;
  assign rot_l   = dbl << amt;
  assign sra_val = $signed(q) >>> amt;

  // Select the result for the requested operation.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q_next    = q;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    unique case (mode)
      SRL: if (amt_ok) begin
        q_next    = q >> amt;
        bit_out   = pre_r[0];
        bit_valid = 1'b1;
      end
      SRA: if (amt_ok) begin
        q_next    = sra_val;
        bit_out   = pre_r[0];
        bit_valid = 1'b1;
      end
      SLL: if (amt_ok) begin
        q_next    = q << amt;
        bit_out   = pre_l[WIDTH-1];
        bit_valid = 1'b1;
      end
      ROR: if (amt_ok) begin
        q_next    = rot_r[WIDTH-1:0];
        bit_out   = pre_r[0];
        bit_valid = 1'b1;
      end
      ROL: if (amt_ok) begin
        q_next    = rot_l[2*WIDTH-1:WIDTH];
        bit_out   = pre_l[WIDTH-1];
        bit_valid = 1'b1;
      end
      SIR: begin
        q_next    = {ser_in, q[WIDTH-1:1]};
        bit_out   = q[0];
        bit_valid = 1'b1;
      end
      SIL: begin
        q_next    = {q[WIDTH-2:0], ser_in};
        bit_out   = q[WIDTH-1];
        bit_valid = 1'b1;
      end
      default: begin
        q_next    = q;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
      end
    endcase
  end

endmodule : usr_shift_core

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, single-step shifts on ena, and an
// autonomous burst of N steps with a busy/done handshake.
// Edge priority: reset > load > burst step > burst accept > ena step.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   data,
  input  logic               ena,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               ser_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   count,
  output logic [WIDTH-1:0]   q,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  usr_state_e         state,    state_n;
  logic [CNT_W-1:0]   rem,      rem_n;
  usr_mode_e          lat_mode, lat_mode_n;
  logic [SHAMT_W-1:0] lat_amt,  lat_amt_n;
  logic [WIDTH-1:0]   q_n;
  logic               ser_n;
  logic               done_n;

  usr_mode_e          core_mode;
  logic [SHAMT_W-1:0] core_amt;
  logic [WIDTH-1:0]   core_q;
  logic               core_bit;
  logic               core_valid;

  // During a burst the latched operation drives the datapath; otherwise the live inputs.
  assign core_mode = (state == RUN) ? lat_mode : usr_mode_e'(mode);
  assign core_amt  = (state == RUN) ? lat_amt  : amt;
  assign busy      = (state == RUN);

  usr_shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .q         (q),
    .mode      (core_mode),
    .amt       (core_amt),
    .ser_in    (ser_in),
    .q_next    (core_q),
    .bit_out   (core_bit),
    .bit_valid (core_valid)
  );

  // Next-state and next-output selection in edge-priority order.
  always_comb begin
    state_n    = state;
    rem_n      = rem;
    lat_mode_n = lat_mode;
    lat_amt_n  = lat_amt;
    q_n        = q;
    ser_n      = ser_out;
    done_n     = 1'b0;

    if (load) begin
      // A load aborts any burst silently: no done pulse.
      q_n     = data;
      state_n = IDLE;
      rem_n   = '0;
    end else if (state == RUN) begin
      q_n   = core_q;
      if (core_valid) ser_n = core_bit;
      rem_n = rem - CNT_W'(1);
      if (rem == CNT_W'(1)) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end else if (start) begin
      // Accept edge: latch the operation, no shift this cycle.
      if (count != '0) begin
        state_n    = RUN;
        rem_n      = count;
        lat_mode_n = usr_mode_e'(mode);
        lat_amt_n  = amt;
      end else begin
        done_n = 1'b1;
      end
    end else if (ena) begin
      q_n = core_q;
      if (core_valid) ser_n = core_bit;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      lat_mode <= SRL;
      lat_amt  <= '0;
      q        <= '0;
      ser_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      lat_mode <= lat_mode_n;
      lat_amt  <= lat_amt_n;
      q        <= q_n;
      ser_out  <= ser_n;
      done     <= done_n;
    end
  end

endmodule : univ_shift_reg
